apb_master_ctrl: RTL and testbench

APB requester that turns a simple command/response interface into APB SETUP/ACCESS transfers toward the timer register block. Used by the test harness and by the on-chip sequencer to program TDR (0x00) and TCR (0x01), and to read or clear TSR (0x02). It issues one transfer at a time, waits on pready, and returns read data and error status. A watchdog aborts transfers whose pready never arrives.

---
 rtl/apb_master_ctrl.sv | 178 +++++++++++++++++
 tb/tb_apb_master_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/apb_master_ctrl.sv
// APB requester: turns a single-outstanding command/response handshake into
// APB SETUP/ACCESS transfers, with a watchdog that aborts a transfer when
// pready never arrives.
module apb_master_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic              pclk,
  input  logic              presetn,
  // command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response side
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  // APB requester side
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  // The watchdog fires when the counter has already seen TIMEOUT-1 waits and
  // this ACCESS edge still has no pready; TIMEOUT = 0 turns it off entirely.
  localparam bit              WDOG_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] WDOG_LAST = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [TO_W-1:0] WDOG_MAX  = {TO_W{1'b1}};
  localparam logic [TO_W-1:0] WDOG_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

  state_e              state_q,       state_d;
  logic                psel_q,        psel_d;
  logic                penable_q,     penable_d;
  logic                pwrite_q,      pwrite_d;
  logic [ADDR_W-1:0]   paddr_q,       paddr_d;
  logic [DATA_W-1:0]   pwdata_q,      pwdata_d;
  logic                rsp_valid_q,   rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q,   rsp_rdata_d;
  logic                rsp_err_q,     rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic [TO_W-1:0]     wdog_q,        wdog_d;
  logic                wdog_expire_s;

  // Expiry decode from the current watchdog count.
  always_comb begin
    wdog_expire_s = WDOG_EN && (wdog_q == WDOG_LAST);
  end

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    wdog_d        = wdog_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          // reads park pwdata at zero so the bus does not toggle for nothing
          pwdata_d  = cmd_write ? cmd_wdata : {DATA_W{1'b0}};
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end else begin
          state_d   = ST_IDLE;
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        wdog_d    = {TO_W{1'b0}};
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (pready) begin
          // pready wins over a same-edge watchdog expiry
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite_q ? {DATA_W{1'b0}} : prdata;
          state_d       = ST_IDLE;
        end else if (wdog_expire_s) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = {DATA_W{1'b0}};
          state_d       = ST_IDLE;
        end else begin
          if (wdog_q != WDOG_MAX) begin
            wdog_d = wdog_q + WDOG_ONE;
          end else begin
            wdog_d = wdog_q;
          end
        end
      end

      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and registered-output flops; reset releases the bus at once.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= ST_IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= {ADDR_W{1'b0}};
      pwdata_q      <= {DATA_W{1'b0}};
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= {DATA_W{1'b0}};
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wdog_q        <= {TO_W{1'b0}};
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      wdog_q        <= wdog_d;
    end
  end

  // Output mapping; cmd_ready is a pure decode of the IDLE state.
  always_comb begin
    cmd_ready   = (state_q == ST_IDLE);
    psel        = psel_q;
    penable     = penable_q;
    pwrite      = pwrite_q;
    paddr       = paddr_q;
    pwdata      = pwdata_q;
    rsp_valid   = rsp_valid_q;
    rsp_rdata   = rsp_rdata_q;
    rsp_err     = rsp_err_q;
    rsp_timeout = rsp_timeout_q;
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl with a small APB slave model and a
// response scoreboard.
module tb_apb_master_ctrl;

  localparam int TO = 4;

  logic       pclk = 1'b0;
  logic       presetn;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_err, rsp_timeout;
  logic [7:0] rsp_rdata;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata, prdata;
  logic       pready, pslverr;

  apb_master_ctrl #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO), .TO_W(3)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // slave model: pready after slv_waits wait cycles; slv_waits < 0 = never
  int         slv_waits;
  logic [7:0] slv_rdata;
  logic       slv_err;
  int         acc_cnt;

  always @(posedge pclk) begin
    acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;
  end

  always_comb begin
    pready  = psel && penable && (slv_waits >= 0) && (acc_cnt >= slv_waits);
    prdata  = slv_rdata;
    pslverr = slv_err;
  end

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    logic       to;
  } rsp_t;
  rsp_t sb_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: compare every response pulse against the oldest expectation
  always @(negedge pclk) begin
    if (rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = sb_q.pop_front();
        check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.to});
      end
    end
  end

  // One command from an IDLE negedge; returns at the negedge where rsp_valid is seen.
  task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                      input int waits, input logic [7:0] rd, input logic err,
                      input string tag);
    rsp_t e;
    logic to;
    int   exp_lat;
    int   lat;
    to      = (waits < 0) || (waits >= TO);
    exp_lat = to ? (2 + TO) : (3 + waits);
    e.to    = to;
    e.err   = to ? 1'b1 : err;
    e.rdata = (to || w) ? 8'h00 : rd;
    sb_q.push_back(e);
    slv_waits = waits;
    slv_rdata = rd;
    slv_err   = err;
    check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge pclk);
      if (k == 1) cmd_valid = 1'b0;
      if (rsp_valid === 1'b1) begin
        lat = k;
        break;
      end
      check({tag, "_busy"}, {31'd0, cmd_ready}, 32'd0);
      check({tag, "_psel"}, {31'd0, psel}, 32'd1);
      check({tag, "_penable"}, {31'd0, penable}, (k >= 2) ? 32'd1 : 32'd0);
      check({tag, "_paddr"}, {24'd0, paddr}, {24'd0, a});
      check({tag, "_pwrite"}, {31'd0, pwrite}, {31'd0, w});
      check({tag, "_pwdata"}, {24'd0, pwdata}, w ? {24'd0, d} : 32'd0);
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_psel_done"}, {31'd0, psel}, 32'd0);
    check({tag, "_penable_done"}, {31'd0, penable}, 32'd0);
  endtask

  initial begin
    presetn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 8'h00;
    cmd_wdata = 8'h00;
    slv_waits = 0;
    slv_rdata = 8'h00;
    slv_err   = 1'b0;
    acc_cnt   = 0;
    repeat (2) @(negedge pclk);
    check("rst_psel", {31'd0, psel}, 32'd0);
    check("rst_penable", {31'd0, penable}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    presetn = 1'b1;
    @(negedge pclk);
    check("idle_pwrite", {31'd0, pwrite}, 32'd0);
    check("idle_paddr", {24'd0, paddr}, 32'd0);
    check("idle_pwdata", {24'd0, pwdata}, 32'd0);
    check("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("idle_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    check("idle_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("idle_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);

    // zero-wait write
    xfer(1'b1, 8'h00, 8'hA5, 0, 8'h5C, 1'b0, "wr_a5");
    @(negedge pclk);
    check("wr_a5_pulse", {31'd0, rsp_valid}, 32'd0);

    // read with two wait states
    xfer(1'b0, 8'h01, 8'h99, 2, 8'hB3, 1'b0, "rd_b3");
    @(negedge pclk);
    check("rd_b3_pulse", {31'd0, rsp_valid}, 32'd0);
    check("rd_b3_hold", {24'd0, rsp_rdata}, 32'h0000_00B3);

    // slave error, then a command accepted on the rsp_valid cycle
    xfer(1'b0, 8'h05, 8'h00, 0, 8'h5A, 1'b1, "rd_err");
    xfer(1'b1, 8'h01, 8'h3C, 1, 8'h00, 1'b0, "b2b_wr");
    @(negedge pclk);

    // watchdog abort: pready never comes
    xfer(1'b0, 8'h02, 8'h00, -1, 8'h77, 1'b0, "timeout");
    @(negedge pclk);
    check("timeout_hold", {31'd0, rsp_timeout}, 32'd1);

    // pready on the very edge the watchdog would expire
    xfer(1'b0, 8'h02, 8'h00, TO - 1, 8'h66, 1'b0, "ready_at_expiry");
    @(negedge pclk);

    // reset while in ACCESS
    slv_waits = -1;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h02;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    check("mid_penable_pre", {31'd0, penable}, 32'd1);
    #2 presetn = 1'b0;
    #1;
    check("mid_psel_async", {31'd0, psel}, 32'd0);
    check("mid_penable_async", {31'd0, penable}, 32'd0);
    check("mid_ready_async", {31'd0, cmd_ready}, 32'd1);
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    xfer(1'b1, 8'h02, 8'h03, 0, 8'h00, 1'b0, "post_rst_wr");
    @(negedge pclk);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
